// File: rtl/landing_lock_if.sv
// landing_lock_if: bundle between piece-position logic (master) and the
// landing/lock controller (slave).
interface landing_lock_if #(
  parameter int COLS = 10,
  parameter int HW   = 5
) ();
  logic               frame_tick;
  logic               piece_valid;
  logic [15:0]        shape;
  logic [9:0]         ref_x;
  logic [9:0]         ref_y;
  logic [COLS*HW-1:0] col_height;
  logic               move_event;
  logic               hard_drop;
  logic               lock_ack;
  logic               stop;
  logic               lock;

  modport master (
    output frame_tick, piece_valid, shape, ref_x, ref_y, col_height,
           move_event, hard_drop, lock_ack,
    input  stop, lock
  );

  modport slave (
    input  frame_tick, piece_valid, shape, ref_x, ref_y, col_height,
           move_event, hard_drop, lock_ack,
    output stop, lock
  );
endinterface

// File: rtl/landing_lock_ctrl.sv
// landing_lock_ctrl: detects when the falling 4x4 piece rests on the floor or
// the stack, holds off gravity, and raises a lock request after a frame-based
// lock delay (or immediately on hard drop while touching).
// Optional feature macro: LOCK_RESET_EN -- a move/rotate while landed restarts
// the lock delay, at most 15 times per piece.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no active piece; waiting for piece_valid
// S_FALLING | piece active, not touching
// S_LANDED  | piece touching; lock-delay counter runs on frame_tick
// S_LOCK    | lock request raised; waiting for lock_ack
module landing_lock_ctrl #(
  parameter int SIZE       = 16,
  parameter int SCREEN_H   = 480,
  parameter int COLS       = 10,
  parameter int ROWS       = 30,
  parameter int X0         = 0,
  parameter int LOCK_DELAY = 30
) (
  input  logic          clk,
  input  logic          resetn,
  landing_lock_if.slave bus
);

  localparam int HW    = $clog2(ROWS + 1);
  localparam int SHIFT = $clog2(SIZE);
  localparam int CW    = (LOCK_DELAY > 0) ? $clog2(LOCK_DELAY + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (LOCK_DELAY > 0) ? CW'(LOCK_DELAY - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FALLING = 2'd1,
    S_LANDED  = 2'd2,
    S_LOCK    = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_touch_q;
  logic          w_touch;

`ifdef LOCK_RESET_EN
  logic [3:0]    r_mv_cnt;
  logic [3:0]    w_mv_nxt;
`else
  logic          w_unused_move;
  assign w_unused_move = bus.move_event;
`endif

  // Per piece column: does it hold any cell, and which row is its bottom-most cell
  logic [3:0] w_col_any;
  logic [1:0] w_lo [4];

  // Scan each mask column top to bottom; the last set row found is the lowest
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      w_col_any[c] = 1'b0;
      w_lo[c]      = 2'd0;
      for (int r = 0; r < 4; r++) begin
        if (bus.shape[4*r+c]) begin
          w_col_any[c] = 1'b1;
          w_lo[c]      = r[1:0];
        end
      end
    end
  end

  // Playfield column under piece column 0; a left-of-X0 position wraps to a
  // large value and is then rejected by the COLS bound below
  logic [10:0] w_rel_x;
  logic [10:0] w_base_col;
  assign w_rel_x    = 11'(bus.ref_x) - 11'(X0);
  assign w_base_col = w_rel_x >> SHIFT;

  logic [10:0]   w_k;
  logic [HW-1:0] w_h;
  logic [11:0]   w_bottom;
  logic [11:0]   w_stack;

  // Touch test: bottom >= SCREEN_H - h*SIZE, rearranged as
  // bottom + h*SIZE >= SCREEN_H so a tall stack cannot underflow the floor
  always_comb begin
    w_touch  = 1'b0;
    w_k      = '0;
    w_h      = '0;
    w_bottom = '0;
    w_stack  = '0;
    for (int c = 0; c < 4; c++) begin
      w_k = w_base_col + 11'(c);
      w_h = '0;
      for (int kk = 0; kk < COLS; kk++) begin
        if (w_k == 11'(kk)) w_h = bus.col_height[kk*HW +: HW];
      end
      w_bottom = 12'(bus.ref_y) + ((12'(w_lo[c]) + 12'd1) << SHIFT);
      w_stack  = 12'(w_h) << SHIFT;
      if (w_col_any[c] && (w_k < 11'(COLS)) &&
          ((w_bottom + w_stack) >= 12'(SCREEN_H))) begin
        w_touch = 1'b1;
      end
    end
  end

  // State, lock-delay counter and registered touch flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_touch_q <= 1'b0;
`ifdef LOCK_RESET_EN
      r_mv_cnt  <= 4'd0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_touch_q <= w_touch;
`ifdef LOCK_RESET_EN
      r_mv_cnt  <= w_mv_nxt;
`endif
    end
  end

  // Next-state and counter update; hard_drop outranks tick and move,
  // losing contact outranks everything in LANDED
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
`ifdef LOCK_RESET_EN
    w_mv_nxt    = r_mv_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (bus.piece_valid) w_state_nxt = S_FALLING;
      end
      S_FALLING: begin
        w_cnt_nxt = '0;
        if (r_touch_q) w_state_nxt = bus.hard_drop ? S_LOCK : S_LANDED;
      end
      S_LANDED: begin
        if (!r_touch_q) begin
          w_state_nxt = S_FALLING;
          w_cnt_nxt   = '0;
        end else if (bus.hard_drop) begin
          w_state_nxt = S_LOCK;
          w_cnt_nxt   = '0;
        end else if (LOCK_DELAY == 0) begin
          w_state_nxt = S_LOCK;
          w_cnt_nxt   = '0;
`ifdef LOCK_RESET_EN
        end else if (bus.move_event && (r_mv_cnt != 4'd15)) begin
          w_cnt_nxt = '0;
          w_mv_nxt  = r_mv_cnt + 4'd1;
`endif
        end else if (bus.frame_tick) begin
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = S_LOCK;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      S_LOCK: begin
        w_cnt_nxt = '0;
        if (bus.lock_ack) begin
          w_state_nxt = S_IDLE;
`ifdef LOCK_RESET_EN
          w_mv_nxt    = 4'd0;
`endif
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs decode straight from registers so reset clears them at once
  assign bus.stop = r_touch_q & ((r_state == S_FALLING) || (r_state == S_LANDED));
  assign bus.lock = (r_state == S_LOCK);

endmodule
